// File: rtl/spi_mnrch_pkg.sv
// rtl/spi_mnrch_pkg.sv - shared state type, width helpers and divider reload value for the SPI monarch
package spi_mnrch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_BACK  = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_t;

  // Width needed to hold a frame length of 0..data_w
  function automatic int len_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

  // Width of the slave index; never narrower than one bit
  function automatic int sel_w(input int num_ss);
    return (num_ss > 1) ? $clog2(num_ss) : 1;
  endfunction

  // Divider park value: SCLK high, 9 clk before the first falling edge for div_w=5
  function automatic int ld_val(input int div_w);
    return (1 << div_w) - (1 << (div_w - 2)) - 1;
  endfunction

  localparam int LEN_W = len_w(16);
  localparam int SEL_W = sel_w(1);

endpackage

// File: rtl/spi_mnrch_cfg_if.sv
// rtl/spi_mnrch_cfg_if.sv - front-end request/response bundle for the SPI monarch
interface spi_mnrch_cfg_if
  import spi_mnrch_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_SS = 1
);

  localparam int LW = len_w(DATA_W);
  localparam int SW = sel_w(NUM_SS);

  logic              snd;
  logic [DATA_W-1:0] cmd;
  logic [LW-1:0]     len;
  logic [SW-1:0]     ss_sel;
  logic              hold_ss;
  logic              done;
  logic              busy;
  logic [DATA_W-1:0] resp;

  modport master (
    output snd, cmd, len, ss_sel, hold_ss,
    input  done, busy, resp
  );

  modport slave (
    input  snd, cmd, len, ss_sel, hold_ss,
    output done, busy, resp
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SCLK divider with park/reload, end-of-period and sample strobes
module spi_sclk_gen
  import spi_mnrch_pkg::*;
#(
  parameter int DIV_W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic sclk,
  output logic full,
  output logic shft
);

  localparam logic [DIV_W-1:0] LD      = DIV_W'(ld_val(DIV_W));
  localparam logic [DIV_W-1:0] SHFT_AT = DIV_W'((1 << (DIV_W - 1)) + 1);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Park at the reload value when asked, otherwise free-run
  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (load) begin
      cnt_d = LD;
    end
  end

  // Counter register; reset parks SCLK high
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= LD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sclk = cnt_q[DIV_W-1];
  assign full = &cnt_q;
  assign shft = (cnt_q == SHFT_AT);

endmodule

// File: rtl/spi_mnrch_cfg.sv
// rtl/spi_mnrch_cfg.sv - mode-3 SPI monarch with runtime length, one-hot selects and burst hold
module spi_mnrch_cfg
  import spi_mnrch_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIV_W  = 5,
  parameter int NUM_SS = 1
) (
  input  logic              clk,
  input  logic              rst,
  spi_mnrch_cfg_if.slave    bus,
  output logic [NUM_SS-1:0] SS_n,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int LW = len_w(DATA_W);
  localparam int SW = sel_w(NUM_SS);

  spi_state_t        state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [LW-1:0]     bit_q, bit_d;
  logic [LW-1:0]     len_q, len_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic              hold_q, hold_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              div_load;
  logic              full;
  logic              shft;
  logic              accept;
  logic [LW-1:0]     len_eff;

  // Divider is parked while idle or holding, and reloaded at the end of a frame
  // so SCLK never dips low after the last bit
  assign div_load = (state_q == ST_IDLE) || (state_q == ST_HOLD) ||
                    ((state_q == ST_BACK) && full);

  spi_sclk_gen #(
    .DIV_W (DIV_W)
  ) u_sclk_gen (
    .clk  (clk),
    .rst  (rst),
    .load (div_load),
    .sclk (SCLK),
    .full (full),
    .shft (shft)
  );

  // Next-state and datapath decisions for the frame sequencer
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    len_d   = len_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    ss_n_d  = ss_n_q;
    done_d  = done_q;
    busy_d  = busy_q;
    accept  = 1'b0;

    // Zero (or anything out of range) means a full-width frame
    if ((bus.len == '0) || (int'(bus.len) > DATA_W)) begin
      len_eff = LW'(DATA_W);
    end else begin
      len_eff = bus.len;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.snd && (int'(bus.ss_sel) < NUM_SS)) begin
          accept = 1'b1;
          sel_d  = bus.ss_sel;
          ss_n_d = ~(NUM_SS'(1) << bus.ss_sel);
        end
      end
      ST_HOLD: begin
        if (bus.snd) begin
          accept = 1'b1;
          ss_n_d = ~(NUM_SS'(1) << sel_q);
        end
      end
      ST_SHIFT: begin
        if (bit_q == len_q) begin
          state_d = ST_BACK;
        end else if (shft) begin
          tx_d  = {tx_q[DATA_W-2:0], 1'b0};
          rx_d  = {rx_q[DATA_W-2:0], MISO};
          bit_d = bit_q + LW'(1);
        end
      end
      ST_BACK: begin
        if (full) begin
          done_d = 1'b1;
          busy_d = 1'b0;
          if (hold_q) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
            ss_n_d  = '1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      state_d = ST_SHIFT;
      tx_d    = bus.cmd << (DATA_W - int'(len_eff));
      rx_d    = '0;
      bit_d   = '0;
      len_d   = len_eff;
      hold_d  = bus.hold_ss;
      done_d  = 1'b0;
      busy_d  = 1'b1;
    end
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      len_q   <= '0;
      sel_q   <= '0;
      hold_q  <= 1'b0;
      ss_n_q  <= '1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      len_q   <= len_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      ss_n_q  <= ss_n_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign SS_n     = ss_n_q;
  assign MOSI     = tx_q[DATA_W-1];
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.resp = rx_q;

endmodule

// File: doc/spi_mnrch_cfg.md
Name: spi_mnrch_cfg

Overview:
Parametrised SPI monarch (master), mode 3 (SCLK idles high; MOSI changes on the falling edge; MISO is sampled just after the rising edge).
Generalised from the fixed 16-bit, single-slave version:
- runtime frame length 1..DATA_W
- NUM_SS one-hot slave selects
- optional SS hold for back-to-back burst frames
- busy status output
It sits between sensor/ADC front-end FSMs and the off-chip SPI devices.

Parameters:
DATA_W, 16, maximum frame width in bits.
DIV_W, 5, SCLK divider width; SCLK period = 2^DIV_W clk (min 3).
NUM_SS, 1, number of slave-select lines.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
snd  in  1  start request, sampled when not busy
cmd  in  DATA_W  transmit word; cmd[len-1:0] sent MSB first
len  in  LEN_W=$clog2(DATA_W+1)  frame length; 0 is treated as DATA_W
ss_sel  in  SEL_W=max(1,$clog2(NUM_SS))  target slave index
hold_ss  in  1  keep SS asserted after this frame
SS_n  out  NUM_SS  active-low slave selects
SCLK  out  1  serial clock
MOSI  out  1  serial data out
MISO  in  1  serial data in
done  out  1  sticky frame-complete flag
busy  out  1  high in SHIFT/BACK states
resp  out  DATA_W  received bits, right-justified, upper bits 0

Behaviour:
Reset values:
- SS_n all 1, SCLK 1, MOSI 0, done 0, busy 0, resp 0, state IDLE.
- Reset mid-frame aborts immediately: SS_n releases on the next edge and no done is set.

Divider (cnt, DIV_W bits):
- SCLK = cnt[MSB].
- Reload value LD = 2^DIV_W - 2^(DIV_W-2) - 1 (23 for defaults). cnt is held at LD in IDLE and HOLD; it increments otherwise.
- full = (cnt all ones).
- shft = (cnt == 2^(DIV_W-1) + 1), i.e. 2 clk after each SCLK rise.

States: IDLE, SHIFT, BACK, HOLD (enum in package).
- IDLE: on snd, latch len, ss_sel and hold_ss.
  - Load tx shift register with cmd << (DATA_W-len).
  - Clear rx register and bit counter; clear done.
  - Drive SS_n[ss_sel] low on the next edge; go to SHIFT.
  - ss_sel >= NUM_SS: request ignored, stays IDLE.
- SHIFT: MOSI = tx[MSB].
  - On shft: tx shifts left; rx <= {rx, MISO}; bit counter increments.
  - When bit counter == latched len: go to BACK.
  - snd is ignored while busy (no restart).
- BACK: wait for full.
  - In that cycle reload cnt, so SCLK stays high with no glitch low.
  - Set done.
  - Next state is HOLD if hold_ss was latched 1; otherwise IDLE with SS_n all high on the same edge.
- HOLD: SS_n stays low, SCLK high, done stays 1.
  - snd behaves as in IDLE, except SS_n does not toggle and ss_sel is ignored (the latched slave is kept).
  - The new hold_ss is latched; a frame with hold_ss=0 ends the burst.

Outputs:
- resp = rx register, continuously driven.
- busy = (state==SHIFT || state==BACK).
- done holds until the next accepted snd or rst.

Latency (defaults):
- Accepted snd at edge T0; SCLK first falls after T9.
- done rises at edge T0 + 521 - 32*(DATA_W-len); len=16 gives 521, len=8 gives 265.
- SS_n releases on the same edge that done rises.

Decomposition:
- spi_mnrch_pkg: spi_state_t enum; function ld_val(DIV_W); localparams LEN_W and SEL_W.
- One natural sub-module, spi_sclk_gen: divider with reload, SCLK, full and shft outputs, parametrised by DIV_W.

Test Plan:
1. Defaults, cmd=16'hA5C3, len=0, MISO loops back MOSI -> MOSI bits match A5C3 MSB first; resp=16'hA5C3; done rises 521 clk after snd; exactly 16 SCLK falls.
2. len=8, cmd=16'h00B7, MISO held 1 -> 8 SCLK pulses; resp=16'h00FF; done rises at +265.
3. NUM_SS=4, ss_sel=2 -> only SS_n[2] goes low; ss_sel=5 -> no activity, done stays 0.
4. Burst: frame 1 with hold_ss=1, then snd with hold_ss=0 -> SS_n[sel] is low continuously across both frames; done clears at the second snd; SS_n goes high with the final done.
5. snd pulsed again during SHIFT -> ignored; resp and timing identical to scenario 1.
6. rst asserted at clk 200 of a frame -> next edge: SS_n all 1, SCLK 1, done 0, busy 0; a new snd then completes normally.
